// File: rtl/seg_scan_pkg.sv
// Shared types and sizing for the 4-digit multiplexed segment scanner.
// Optional feature macro used by this block: SEG_LZB_EN (leading-zero blanking).
package seg_scan_pkg;
  localparam int NIB_W   = 4;
  localparam int NUM_DIG = 4;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_e;

  // One counter serves both dwells, so size it for the longer one.
  function automatic int cnt_w(input int div_max, input int gap_cyc);
    int m;
    m = (div_max > gap_cyc) ? div_max : gap_cyc;
    return (m <= 1) ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/seg_scan_if.sv
// Load/display bus of the segment scanner; master drives load/din, slave drives the mux and enables.
interface seg_scan_if;
  import seg_scan_pkg::*;
  logic             load;
  logic [15:0]      din;
  logic [NIB_W-1:0] ic0, ic1, ic2, ic3;
  logic             is0, is1;
  logic [NUM_DIG-1:0] an;
  logic             pend;

  modport master (output load, din, input ic0, ic1, ic2, ic3, is0, is1, an, pend);
  modport slave  (input load, din, output ic0, ic1, ic2, ic3, is0, is1, an, pend);
endinterface

// File: rtl/seg_scan_div.sv
// Shared dwell counter: counts the current GAP or SHOW dwell and flags its last cycle.
module seg_scan_div
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX = 49999,
  parameter int GAP_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic show_i,
  output logic tc_o
);
  localparam int CW = cnt_w(DIV_MAX, GAP_CYC);
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_MAX);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = show_i ? (cnt_q == DIV_LAST) : (cnt_q == GAP_LAST);

  // Terminal count always coincides with a state change, so it doubles as the clear.
  always_comb cnt_d = tc_o ? '0 : cnt_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit scan controller: GAP/SHOW FSM, frame-synchronous display buffer and shadow load.
// Define SEG_LZB_EN to blank leading zero digits during SHOW.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIV_MAX = 49999,
  parameter int GAP_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  seg_scan_if.slave  bus
);
  state_e                         state_q;
  logic [1:0]                     sel_q;
  logic [NUM_DIG-1:0]             an_q;
  logic [NUM_DIG-1:0][NIB_W-1:0]  disp_q, disp_d, shadow_q, shadow_d;
  logic                           pend_q, pend_d;
  logic                           tc, wrap;
  logic [NUM_DIG-1:0]             en_mask;

  seg_scan_div #(.DIV_MAX(DIV_MAX), .GAP_CYC(GAP_CYC)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .show_i (state_q == ST_SHOW),
    .tc_o   (tc)
  );

  assign wrap = (state_q == ST_SHOW) && tc && (sel_q == 2'd3);

`ifdef SEG_LZB_EN
  // Buffer only changes at the frame wrap (in GAP), so it is stable across any SHOW dwell.
  always_comb begin
    en_mask    = 4'b0001;
    en_mask[1] = |{disp_q[3], disp_q[2], disp_q[1]};
    en_mask[2] = |{disp_q[3], disp_q[2]};
    en_mask[3] = |disp_q[3];
  end
`else
  assign en_mask = '1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_GAP;
      sel_q   <= 2'd0;
      an_q    <= '1;
    end else begin
      case (state_q)
        ST_GAP: if (tc) begin
          state_q <= ST_SHOW;
          an_q    <= ~((4'b0001 << sel_q) & en_mask);
        end
        ST_SHOW: if (tc) begin
          state_q <= ST_GAP;
          an_q    <= '1;
          sel_q   <= sel_q + 2'd1;
        end
        default: begin
          state_q <= ST_GAP;
          an_q    <= '1;
        end
      endcase
    end
  end

  // A load coincident with the wrap: old shadow goes to the buffer, new din stays pending.
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (wrap && pend_q) begin
      disp_d = shadow_q;
      pend_d = 1'b0;
    end
    if (bus.load) begin
      shadow_d = bus.din;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.is0  = sel_q[0];
  assign bus.is1  = sel_q[1];
  assign bus.ic0  = disp_q[0];
  assign bus.ic1  = disp_q[1];
  assign bus.ic2  = disp_q[2];
  assign bus.ic3  = disp_q[3];
  assign bus.pend = pend_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed + randomized bench for seg_scan_ctrl with a cycle-position reference model.
module tb_seg_scan_ctrl;
  localparam int DIV   = 3;
  localparam int GAP   = 2;
  localparam int SLOT  = GAP + DIV + 1;
  localparam int FRAME = 4 * SLOT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  seg_scan_if bus();

  seg_scan_ctrl #(.DIV_MAX(DIV), .GAP_CYC(GAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: position t (cycles since reset release) fixes sel/an; display follows the load rules.
  int          t = 0;
  logic [15:0] m_shadow = '0;
  logic        m_pend = 1'b0;
  logic [15:0] m_disp = '0;

  function automatic logic [3:0] exp_an(input int tt, input logic [15:0] d);
    int s;
    logic [3:0] a;
    s = (tt / SLOT) % 4;
    a = 4'b1111;
    if ((tt % SLOT) >= GAP) begin
      a[s] = 1'b0;
`ifdef SEG_LZB_EN
      if (s == 3 && d[15:12] == 4'h0) a = 4'b1111;
      if (s == 2 && d[15:8]  == 8'h0) a = 4'b1111;
      if (s == 1 && d[15:4]  == 12'h0) a = 4'b1111;
`endif
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h t=%0d", tag, obs, exp, t);
    end
  endtask

  function automatic logic [15:0] disp_obs();
    return {bus.ic3, bus.ic2, bus.ic1, bus.ic0};
  endfunction

  task automatic check_all();
    chk("an",   32'(bus.an), 32'(exp_an(t, m_disp)));
    chk("sel",  32'({bus.is1, bus.is0}), 32'((t / SLOT) % 4));
    chk("pend", 32'(bus.pend), 32'(m_pend));
    chk("disp", 32'(disp_obs()), 32'(m_disp));
  endtask

  task automatic tick(input logic ld, input logic [15:0] d);
    bus.load = ld;
    bus.din  = d;
    @(posedge clk);
    if (!rst_n) begin
      t = 0; m_shadow = '0; m_pend = 1'b0; m_disp = '0;
    end else begin
      if ((t % FRAME) == FRAME - 1 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = d;
        m_pend   = 1'b1;
      end
      t++;
    end
    #1;
    bus.load = 1'b0;
    check_all();
  endtask

  task automatic idle_until(input int phase);
    for (int n = 0; n < FRAME && (t % FRAME) != phase; n++) tick(1'b0, 16'h0);
  endtask

  logic [3:0] an_seq [25];
  int         cnt_dig [4];
  int         exp_cnt [4];

  initial begin
    bus.load = 1'b0;
    bus.din  = '0;
    an_seq = '{4'hF,4'hF, 4'hE,4'hE,4'hE,4'hE, 4'hF,4'hF, 4'hD,4'hD,4'hD,4'hD, 4'hF,4'hF,
               4'hB,4'hB,4'hB,4'hB, 4'hF,4'hF, 4'h7,4'h7,4'h7,4'h7, 4'hF};

    // Reset state
    rst_n = 1'b0;
    tick(1'b0, 16'h0);
    tick(1'b0, 16'h0);
    chk("rst_an", 32'(bus.an), 32'hF);
    chk("rst_sel", 32'({bus.is1, bus.is0}), 32'h0);
    rst_n = 1'b1;

    // Scan sequence from reset release, against literal waveform
    for (int i = 0; i < 25; i++) begin
      chk("seq_an", 32'(bus.an), 32'(an_seq[i]));
      if (i == 8) chk("seq_sel1", 32'({bus.is1, bus.is0}), 32'h1);
      tick(1'b0, 16'h0);
    end

    // Load during sel=1; buffer holds until the wrap
    idle_until(FRAME + 8 - FRAME);
    tick(1'b1, 16'h1234);
    idle_until(FRAME - 1);
    chk("pre_wrap_disp", 32'(disp_obs()), 32'h0);
    chk("pre_wrap_pend", 32'(bus.pend), 32'h1);
    tick(1'b0, 16'h0);
    chk("wrap_disp", 32'(disp_obs()), 32'h1234);
    chk("wrap_pend", 32'(bus.pend), 32'h0);

    // Overwrite before wrap
    idle_until(3);
    tick(1'b1, 16'hAAAA);
    idle_until(12);
    tick(1'b1, 16'h5555);
    idle_until(0);
    chk("ovw_disp", 32'(disp_obs()), 32'h5555);

    // Load on the exact wrap cycle while another is pending
    idle_until(5);
    tick(1'b1, 16'h1234);
    idle_until(FRAME - 1);
    tick(1'b1, 16'hBEEF);
    chk("coinc_disp", 32'(disp_obs()), 32'h1234);
    chk("coinc_pend", 32'(bus.pend), 32'h1);
    tick(1'b0, 16'h0);
    idle_until(0);
    chk("coinc_next", 32'(disp_obs()), 32'hBEEF);

    // Mid-SHOW reset at sel=2 with a pending load
    idle_until(3);
    tick(1'b1, 16'hCAFE);
    idle_until(15);
    chk("pre_rst_sel", 32'({bus.is1, bus.is0}), 32'h2);
    rst_n = 1'b0;
    tick(1'b0, 16'h0);
    rst_n = 1'b1;
    chk("mid_rst_an", 32'(bus.an), 32'hF);
    chk("mid_rst_sel", 32'({bus.is1, bus.is0}), 32'h0);
    chk("mid_rst_pend", 32'(bus.pend), 32'h0);
    chk("mid_rst_disp", 32'(disp_obs()), 32'h0);
    tick(1'b0, 16'h0);
    chk("mid_rst_an1", 32'(bus.an), 32'hF);
    tick(1'b0, 16'h0);
    chk("mid_rst_first", 32'(bus.an), 32'hE);

    // Random loads against the model
    repeat (400) tick($urandom_range(0, 7) == 0, 16'($urandom));

    // Digit-enable counts over one frame showing 0050
    idle_until(1);
    tick(1'b1, 16'h0050);
    idle_until(0);
    chk("lzb_disp", 32'(disp_obs()), 32'h0050);
    for (int d = 0; d < 4; d++) cnt_dig[d] = 0;
    for (int c = 0; c < FRAME; c++) begin
      for (int d = 0; d < 4; d++) if (bus.an[d] == 1'b0) cnt_dig[d]++;
      tick(1'b0, 16'h0);
    end
`ifdef SEG_LZB_EN
    exp_cnt = '{DIV + 1, DIV + 1, 0, 0};
`else
    exp_cnt = '{DIV + 1, DIV + 1, DIV + 1, DIV + 1};
`endif
    for (int d = 0; d < 4; d++) chk("dig_cnt", 32'(cnt_dig[d]), 32'(exp_cnt[d]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0d", t);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV_MAX, default 49999, last count of a SHOW dwell; each digit is shown for DIV_MAX+1 cycles.
REQ-002 Parameter GAP_CYC, default 16, number of blanking cycles between digits; legal range is 1 or more.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 load  in  1  single-cycle strobe that captures din into the shadow register.
REQ-006 din  in  16  four packed nibbles; [15:12] is digit 3 and [3:0] is digit 0.
REQ-007 ic0..ic3  out  4 each  display-buffer nibbles that feed the 4:1 nibble mux data inputs.
REQ-008 is0, is1  out  1 each  registered digit select for the mux; {is1,is0} equals sel.
REQ-009 an  out  4  active-low digit enables; at most one bit is low at any time.
REQ-010 pend  out  1  high while the shadow register holds a value not yet transferred.

Function
REQ-011 State machine has two states: GAP (all digits off) and SHOW (one digit on).
REQ-012 A single counter cnt is shared by both states and clears to 0 on every state change.
REQ-013 GAP → SHOW when cnt == GAP_CYC-1; sel is unchanged by this transition.
REQ-014 SHOW → GAP when cnt == DIV_MAX; sel increments by 1 and wraps from 3 to 0.
REQ-015 In SHOW, an[sel] = 0 and all other an bits = 1; in GAP, an = 4'b1111.
REQ-016 an, is0 and is1 are registered outputs and change on the same edge as the state change.
REQ-017 load = 1 writes din into the shadow register and sets pend on the next edge.
REQ-018 A load while pend = 1 overwrites the shadow register; there is no queueing.
REQ-019 Frame boundary is the SHOW → GAP edge where sel wraps from 3 to 0.
- If pend = 1 at that edge: shadow is copied to ic3..ic0 and pend clears.
REQ-020 The display buffer never changes except at a frame boundary, so no frame shows a partial update.
REQ-021 If load and a frame boundary fall on the same cycle:
- the old shadow is transferred;
- the new din is captured into the shadow;
- pend stays 1.
REQ-022 Cycle 0 (first cycle after reset release) is in GAP; the first an assertion (an = 4'b1110) is at cycle GAP_CYC.

Reset
REQ-023 While rst_n = 0 at a clock edge, the block sets:
- state = GAP, cnt = 0, sel = 0;
- an = 4'b1111, is0 = is1 = 0;
- ic0..ic3 = 0, shadow = 0, pend = 0.
REQ-024 A reset mid-SHOW or mid-GAP takes effect on that edge with no completion of the current dwell, and discards any pending load.

Configuration
REQ-025 Macro SEG_LZB_EN enables leading-zero blanking, applied only in SHOW:
- an[3] is held high when ic3 == 0;
- an[2] is held high when ic3 == ic2 == 0;
- an[1] is held high when ic3, ic2 and ic1 are all 0;
- an[0] is never blanked;
- timing and sel sequencing are unchanged.
REQ-026 Without SEG_LZB_EN, all four digits are shown regardless of value.

Structure
REQ-027 Package seg_scan_pkg holds:
- the state encoding (GAP, SHOW);
- NIB_W = 4 and NUM_DIG = 4;
- the counter width function of max(DIV_MAX, GAP_CYC).
REQ-028 One sub-module, seg_scan_div, contains the dwell counter and terminal-count compare; the FSM, registers and blanking logic stay in seg_scan_ctrl.

Verification
REQ-029 Bench uses DIV_MAX = 3 and GAP_CYC = 2. After reset release:
- an = 1111 for 2 cycles, then 1110 for 4, then 1111 for 2, then 1101 with {is1,is0} = 01;
- the sequence continues through 1011 and 0111, then 1110.
REQ-030 load din = 16'h1234 while sel = 1:
- ic3..ic0 stay 0 until the 3 → 0 wrap;
- ic3..ic0 then read 1,2,3,4 and pend drops on the same edge.
REQ-031 load 16'hAAAA, then load 16'h5555 before the wrap: after the wrap, ic3..ic0 read 5,5,5,5.
REQ-032 load 16'hBEEF on the exact wrap cycle while 16'h1234 is pending:
- the display shows 1234 with pend = 1;
- the display shows BEEF after the next frame boundary.
REQ-033 Assert rst_n = 0 for 1 cycle mid-SHOW at sel = 2 with pend = 1:
- the next cycle has an = 1111, sel = 0, pend = 0 and all ic = 0;
- the first an assertion follows 2 cycles later.
REQ-034 With SEG_LZB_EN and 16'h0050 displayed:
- an[3] and an[2] never go low;
- the digit 1 and digit 0 slots each assert for 4 cycles.
- Without the macro, all four digits assert.
